regfile_wr_arbiter: RTL and testbench
=====================================

# regfile_wr_arbiter

Shares the register file's single write port between the in-order pipeline writeback (port A) and a long-latency unit such as mul/div (port B). Port A has fixed priority and no backpressure. Port B writes are buffered in a small FIFO and drained into idle write-port cycles. The block exports per-read-port busy flags for RAW interlock in decode, and optionally requests a pipeline stall when port B starves.

## Interface
- `DEPTH`, 4: FIFO entries for port B. Power of two, 2..16.
- `STARVE_LIMIT`, 8: consecutive lost arbitration cycles before a stall is requested. Range 1..255.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high (`RstEnable` = 1).
- `a_we` in 1: pipeline writeback enable.
- `a_waddr` in `RegAddrBus` (5): pipeline destination register.
- `a_wdata` in `RegBus` (32): pipeline writeback data.
- `b_valid` in 1: port B write request.
- `b_ready` out 1: port B request can be accepted.
- `b_waddr` in 5: port B destination register.
- `b_wdata` in 32: port B data.
- `we`, `waddr`, `wdata` out 1/5/32: regfile write port. Combinational from A inputs and the FIFO head.
- `re1`, `raddr1`, `re2`, `raddr2` in 1/5/1/5: decode read requests, mirrored from the regfile read ports.
- `busy1`, `busy2` out 1: the read target has a pending port-B write.
- `stall_req` out 1: starvation stall request to the pipeline control.
- `b_count` out $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- **A request.** A valid A request is `a_we == WriteEnable` with `a_waddr != 0`. An A write to $0 counts as no request.
- **Port grant.**
  - A valid A request drives `we=1`, `waddr=a_waddr`, `wdata=a_wdata`.
  - Otherwise, if the FIFO is non-empty, the port carries the FIFO head and the head is popped at the clock edge.
  - Otherwise `we=0`, `waddr=0`, `wdata=0`.
- **B enqueue.**
  - `b_ready = (b_count < DEPTH)`. It depends on registered state only; there is no combinational path from `b_valid` or `a_we`.
  - Handshake `b_valid && b_ready` pushes `{b_waddr, b_wdata}` at the edge.
  - If `b_waddr == 0`, the handshake completes but nothing is stored.
- **Push and pop together.** Allowed when not full; `b_count` is unchanged. When full, `b_ready=0`, so there is no push-through.
- **Ordering.** FIFO order is preserved for port B. The block does no WAW checking between A and B; the issue logic uses `busy1`/`busy2` to avoid it.
- **Busy flags.** `busyN = reN && raddrN != 0 && (raddrN matches any valid FIFO entry)`. This includes the head being written this cycle, which is deliberately conservative.
- **Starvation counter** (`starve_cnt`, 8 bits):
  - Clears when the FIFO is empty or a pop occurs.
  - Increments, saturating at `STARVE_LIMIT`, when the FIFO is non-empty and A holds the port.
  - `stall_req = (starve_cnt == STARVE_LIMIT)`.
  - The pipeline must drop `a_we` while `stall_req` is high. If it does not, A still wins and the block stays correct.
- **Reset.** While `rst` is high:
  - FIFO empties; pointers and `b_count` are 0.
  - `starve_cnt=0`, `b_ready=0`, `stall_req=0`, `busy1=busy2=0`.
  - `we=0`, `waddr=0`, `wdata=0`, regardless of A inputs.
  - Reset mid-operation discards all buffered B writes.

## Timing
- **A path.** Zero latency: A inputs appear on the write port in the same cycle, and the regfile updates at that cycle's closing edge.
- **B path.** A handshake at edge N makes the entry visible in cycle N+1. If A is idle, `we=1` in cycle N+1 and the regfile updates at edge N+1. Minimum latency is 1 cycle; worst case is unbounded without starvation control.
- **Busy timing.** `busyN` rises the cycle after the push edge and falls the cycle after the pop edge of the last matching entry.
- **Stall timing.** `stall_req` rises in the cycle after the `STARVE_LIMIT`-th consecutive lost cycle and falls the cycle after the next pop.
- **Pointer wrap.** Pointers wrap modulo DEPTH. Full and empty are distinguished by `b_count`.

## Configuration
- `WRARB_STARVE_EN`:
  - Defined: the starvation counter and `stall_req` are as above.
  - Undefined: the counter is not built, `stall_req` is tied to 0, and port B waits indefinitely behind A.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle with 3 entries buffered → `we=0`, `b_count=0`, `b_ready=0` immediately. After release, `b_ready=1`.
- **Idle drain.** A idle; push B `$5=0x1234` → `we=1`, `waddr=5`, `wdata=0x1234` the next cycle; `busy1` is high for one cycle when `raddr1=5`.
- **Fill and ordering.** A writes every cycle; push 4 B entries (`$1..$4`) → `b_ready=0` after the 4th. Drop A → `$1,$2,$3,$4` drain in order over 4 cycles.
- **$0 filtering.** B push to $0 → accepted, `b_count` unchanged. A write to $0 with a B head pending → the head drains that cycle.
- **Starvation.** With `WRARB_STARVE_EN`, `STARVE_LIMIT=8`, A busy continuously, 1 B entry pending → `stall_req` high in cycle 9. Drop A → pop, then `stall_req=0` the next cycle. Without the macro → `stall_req` stays 0.
- **Full boundary.** Push while popping at `b_count=DEPTH-1` → `b_count` stays at DEPTH-1. Push at DEPTH-1 with no pop → full, `b_ready=0`.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
// Shares the register file's single write port between the in-order pipeline
// writeback (port A, fixed priority, no backpressure) and a long-latency unit
// (port B). Port B writes are buffered in a DEPTH-entry FIFO and drained into
// cycles where A does not write. Busy flags tell decode whether a read
// target still has a buffered B write pending.
//
// Optional feature macro: WRARB_STARVE_EN
//   defined   -> 8-bit starvation counter drives stall_req
//   undefined -> no counter, stall_req tied low, B waits behind A indefinitely
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   a_we, a_waddr, a_wdata       pipeline writeback request (priority)
//   b_valid, b_ready             port B handshake
//   b_waddr, b_wdata             port B write request
//   we, waddr, wdata             register file write port (combinational)
//   re1, raddr1, re2, raddr2     decode read requests
//   busy1, busy2                 read target has a buffered B write
//   stall_req                    starvation stall request
//   b_count                      FIFO occupancy
module regfile_wr_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_we,
  input  logic [4:0]               a_waddr,
  input  logic [31:0]              a_wdata,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [4:0]               b_waddr,
  input  logic [31:0]              b_wdata,
  output logic                     we,
  output logic [4:0]               waddr,
  output logic [31:0]              wdata,
  input  logic                     re1,
  input  logic [4:0]               raddr1,
  input  logic                     re2,
  input  logic [4:0]               raddr2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   b_count
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);

  logic [4:0]       fifo_addr [DEPTH];
  logic [31:0]      fifo_data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic a_req;
  logic fifo_empty;
  logic pop;
  logic push;

  // A write to $0 is architecturally a no-op, so it does not claim the port.
  assign a_req      = a_we && (a_waddr != 5'd0);
  assign fifo_empty = (b_count == '0);
  assign pop        = !a_req && !fifo_empty && !rst;
  // Ready looks only at registered occupancy (and reset), never at b_valid/a_we.
  assign b_ready    = !rst && (b_count < CNT_FULL);
  // A $0 handshake completes but stores nothing.
  assign push       = b_valid && b_ready && (b_waddr != 5'd0);

  // Write port mux: A wins, otherwise the FIFO head, otherwise idle.
  always_comb begin
    we    = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    if (rst) begin
      we    = 1'b0;
    end else if (a_req) begin
      we    = 1'b1;
      waddr = a_waddr;
      wdata = a_wdata;
    end else if (!fifo_empty) begin
      we    = 1'b1;
      waddr = fifo_addr[rd_ptr];
      wdata = fifo_data[rd_ptr];
    end else begin
      we    = 1'b0;
    end
  end

  // FIFO payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_waddr;
      fifo_data[wr_ptr] <= b_wdata;
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      b_count <= '0;
      vld     <= '0;
    end else begin
      // Push and pop never target the same slot: pop needs non-empty,
      // push needs non-full.
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + 1'b1;
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   b_count <= b_count + CNT_ONE;
        2'b01:   b_count <= b_count - CNT_ONE;
        default: b_count <= b_count;
      endcase
    end
  end

  // Busy flags: any valid entry (including the head being written now) matches.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (fifo_addr[i] == raddr1)) begin
        busy1 = 1'b1;
      end else begin
        busy1 = busy1;
      end
      if (vld[i] && (fifo_addr[i] == raddr2)) begin
        busy2 = 1'b1;
      end else begin
        busy2 = busy2;
      end
    end
    if (!re1 || (raddr1 == 5'd0)) begin
      busy1 = 1'b0;
    end else begin
      busy1 = busy1;
    end
    if (!re2 || (raddr2 == 5'd0)) begin
      busy2 = 1'b0;
    end else begin
      busy2 = busy2;
    end
  end

`ifdef WRARB_STARVE_EN
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  logic [7:0] starve_cnt;

  // Starvation counter: counts consecutive cycles where B has data but A
  // holds the port; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 8'd0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= 8'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 8'd1;
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  assign stall_req = (starve_cnt == LIMIT);
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;
`ifdef WRARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_we = 1'b0;
  logic [4:0]  a_waddr = 5'd0;
  logic [31:0] a_wdata = 32'd0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [4:0]  b_waddr = 5'd0;
  logic [31:0] b_wdata = 32'd0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = 5'd0;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = 5'd0;
  logic        busy1;
  logic        busy2;
  logic        stall_req;
  logic [2:0]  b_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard of expected B writes, in push order.
  logic [36:0] bq[$];
  bit          pop_m = 1'b0;

  regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .busy1(busy1), .busy2(busy2), .stall_req(stall_req), .b_count(b_count)
  );

  always #5 clk = ~clk;

  // Scoreboard compare of the write port, sampled mid-cycle.
  initial forever begin
    logic        exp_we;
    logic [4:0]  exp_a;
    logic [31:0] exp_d;
    @(negedge clk);
    exp_we = 1'b0; exp_a = 5'd0; exp_d = 32'd0; pop_m = 1'b0;
    if (!rst) begin
      if (a_we && a_waddr != 5'd0) begin
        exp_we = 1'b1; exp_a = a_waddr; exp_d = a_wdata;
      end else if (bq.size() > 0) begin
        exp_we = 1'b1; {exp_a, exp_d} = bq[0]; pop_m = 1'b1;
      end
    end
    n_checks++;
    if ({we, waddr, wdata} !== {exp_we, exp_a, exp_d})
      $display("FAIL wport t=%0t: got we=%0b waddr=%0d wdata=%h, want we=%0b waddr=%0d wdata=%h",
               $time, we, waddr, wdata, exp_we, exp_a, exp_d);
    else
      n_pass++;
  end

  // Scoreboard update at the clock edge: pop the drained head, push accepted B writes.
  initial forever begin
    bit rdy;
    @(posedge clk);
    if (!rst) begin
      rdy = (bq.size() < DEPTH);
      if (pop_m) void'(bq.pop_front());
      if (b_valid && rdy && b_waddr != 5'd0) bq.push_back({b_waddr, b_wdata});
    end
    pop_m = 1'b0;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    a_we = aw; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({b_ready, b_count, stall_req, busy1, busy2} !== 7'd0)
      $display("FAIL reset_state: got ready=%0b count=%0d stall=%0b busy=%0b%0b, want all 0",
               b_ready, b_count, stall_req, busy1, busy2);
    else n_pass++;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (b_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b want 1", b_ready);
    else n_pass++;
  endtask

  task automatic test_idle_drain();
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    re1 = 1'b1; raddr1 = 5'd5;
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0) $display("FAIL drain_busy_before: got %0b want 0", busy1); else n_pass++;
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b1 || int'(b_count) !== 1)
      $display("FAIL drain_busy_pending: got busy1=%0b count=%0d want 1/1", busy1, b_count);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if (busy1 !== 1'b0 || b_count !== 3'd0)
      $display("FAIL drain_busy_after: got busy1=%0b count=%0d want 0/0", busy1, b_count);
    else n_pass++;
    re1 = 1'b0;
  endtask

  task automatic test_fill_order();
    for (int i = 0; i < 4; i++) begin
      step();
      set_in(1'b1, 5'(10 + i), 32'hA000 + i, 1'b1, 5'(i + 1), 32'hB000 + i);
      @(negedge clk);
      n_checks++;
      if (b_ready !== 1'b1) $display("FAIL fill_ready_%0d: got %0b want 1", i, b_ready); else n_pass++;
    end
    step();
    set_in(1'b1, 5'd15, 32'hA00F, 1'b1, 5'd7, 32'hDEAD);  // refused: FIFO full
    re2 = 1'b1; raddr2 = 5'd3;
    @(negedge clk);
    n_checks++;
    if (b_ready !== 1'b0 || int'(b_count) !== bq.size() || busy2 !== 1'b1)
      $display("FAIL fill_full: got ready=%0b count=%0d busy2=%0b want 0/%0d/1",
               b_ready, b_count, busy2, bq.size());
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      step();
      set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      n_checks++;
      if (int'(b_count) !== 4 - k) $display("FAIL fill_drain_count_%0d: got %0d want %0d", k, b_count, 4 - k);
      else n_pass++;
    end
    step();
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd0 || busy2 !== 1'b0)
      $display("FAIL fill_empty: got count=%0d busy2=%0b want 0/0", b_count, busy2);
    else n_pass++;
    re2 = 1'b0;
  endtask

  task automatic test_zero_filter();
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF);
    step();
    set_in(1'b1, 5'd20, 32'h2020, 1'b1, 5'd6, 32'h6666);
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd0) $display("FAIL zero_push_count: got %0d want 0", b_count); else n_pass++;
    step();
    set_in(1'b1, 5'd0, 32'h0BAD, 1'b0, 5'd0, 32'd0);  // A to $0: head drains
    @(negedge clk);
    n_checks++;
    if (we !== 1'b1 || waddr !== 5'd6) $display("FAIL zero_a_drain: got we=%0b waddr=%0d want 1/6", we, waddr);
    else n_pass++;
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd0) $display("FAIL zero_after: got %0d want 0", b_count); else n_pass++;
  endtask

  task automatic test_starve();
    bit exp;
    step();
    set_in(1'b1, 5'd9, 32'h9999, 1'b1, 5'd12, 32'hCCCC);
    for (int k = 1; k <= 10; k++) begin
      step();
      set_in(1'b1, 5'd9, 32'h9900 + k, 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      exp = STARVE_ON && (k >= STARVE_LIMIT + 1);
      n_checks++;
      if (stall_req !== exp) $display("FAIL starve_cycle_%0d: got %0b want %0b", k, stall_req, exp);
      else n_pass++;
    end
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (stall_req !== STARVE_ON) $display("FAIL starve_pop_cycle: got %0b want %0b", stall_req, STARVE_ON);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if (stall_req !== 1'b0 || b_count !== 3'd0)
      $display("FAIL starve_clear: got stall=%0b count=%0d want 0/0", stall_req, b_count);
    else n_pass++;
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 3; i++) begin
      step();
      set_in(1'b1, 5'd25, 32'h2500 + i, 1'b1, 5'(16 + i), 32'hF000 + i);
    end
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd19, 32'hF003);  // push + pop at DEPTH-1
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd3 || b_ready !== 1'b1)
      $display("FAIL fb_pre: got count=%0d ready=%0b want 3/1", b_count, b_ready);
    else n_pass++;
    step();
    set_in(1'b1, 5'd26, 32'h2600, 1'b1, 5'd21, 32'hF004);  // push, no pop
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd3) $display("FAIL fb_hold: got %0d want 3", b_count); else n_pass++;
    step();
    set_in(1'b1, 5'd26, 32'h2601, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd4 || b_ready !== 1'b0)
      $display("FAIL fb_full: got count=%0d ready=%0b want 4/0", b_count, b_ready);
    else n_pass++;
    step();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    repeat (5) step();
    @(negedge clk);
    n_checks++;
    if (b_count !== 3'd0) $display("FAIL fb_drained: got %0d want 0", b_count); else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      step();
      set_in(1'b1, 5'd27, 32'h2700 + i, 1'b1, 5'(1 + i), 32'hE000 + i);
    end
    step();
    set_in(1'b1, 5'd28, 32'h2800, 1'b0, 5'd0, 32'd0);
    re1 = 1'b1; raddr1 = 5'd2;
    #2;
    rst = 1'b1;
    bq.delete();
    pop_m = 1'b0;
    #1;
    n_checks++;
    if ({we, b_count, b_ready, busy1, stall_req} !== 7'd0)
      $display("FAIL reset_mid: got we=%0b count=%0d ready=%0b busy1=%0b stall=%0b want all 0",
               we, b_count, b_ready, busy1, stall_req);
    else n_pass++;
    step();
    rst = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    n_checks++;
    if (b_ready !== 1'b1 || b_count !== 3'd0 || busy1 !== 1'b0)
      $display("FAIL reset_mid_release: got ready=%0b count=%0d busy1=%0b want 1/0/0", b_ready, b_count, busy1);
    else n_pass++;
    re1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_fill_order();
    test_zero_filter();
    test_starve();
    test_full_boundary();
    test_reset_mid();
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
